matrix_packet_parser: RTL and testbench
=======================================

MATRIX_PACKET_PARSER -- requirements
Module: matrix_packet_parser

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, meaning element width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 32, meaning maximum rows/cols of any matrix; DIM_W = $clog2(MAX_DIM).
REQ-003 SHALL have port eth_refclk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port axiiv, input, 1, serial stream valid; high for the whole packet.
REQ-006 SHALL have port axiid, input, 1, serial data bit, MSB-first, sampled when axiiv=1.
REQ-007 SHALL have port hdr_valid, output, 1, one-cycle pulse when the header is accepted.
REQ-008 SHALL have ports dim_m, dim_k and dim_n, each output, DIM_W+1, decoded sizes 1..MAX_DIM; A is m×k and B is k×n.
REQ-009 SHALL have port elem_valid, output, 1, one-cycle pulse per completed element.
REQ-010 SHALL have port elem_data, output, ELEM_W, element value.
REQ-011 SHALL have port elem_mat, output, 1, matrix select: 0=A, 1=B.
REQ-012 SHALL have ports elem_row and elem_col, each output, DIM_W, element position in its matrix.
REQ-013 SHALL have port pkt_done, output, 1, one-cycle pulse after the last B element.
REQ-014 SHALL have port pkt_err, output, 1, one-cycle pulse on a malformed or truncated packet.

Function
REQ-015 Packet format SHALL be a 16-bit header then m*k A elements then k*n B elements, all MSB-first.
REQ-016 Header bits [15:11]=m-1, [10:6]=k-1, [5:1]=n-1, [0]=reserved and must be 0.
REQ-017 A elements SHALL arrive row-major (col fastest); B elements SHALL arrive column-major (row fastest).
REQ-018 FSM states SHALL be IDLE, HEADER, LOAD_A, LOAD_B, DRAIN.
REQ-019 IDLE→HEADER on the first cycle with axiiv=1; that bit is header bit 15.
REQ-020 HEADER→LOAD_A after 16 bits when the reserved bit is 0; hdr_valid pulses and dim_* update on the cycle after the 16th bit.
REQ-021 If the reserved bit is 1, SHALL pulse pkt_err and enter DRAIN.
REQ-022 elem_valid SHALL pulse the cycle after the ELEM_W-th bit of each element is sampled; fixed latency 1 cycle.
REQ-023 elem_data, elem_mat, elem_row and elem_col SHALL be valid only while elem_valid=1 and hold their values otherwise.
REQ-024 A indices SHALL increment col 0..k-1 then wrap to 0 and increment row, up to m-1.
REQ-025 B indices SHALL increment row 0..k-1 then wrap to 0 and increment col, up to n-1.
REQ-026 LOAD_A→LOAD_B after element (m-1,k-1); LOAD_B→DRAIN after element (k-1,n-1), with pkt_done in the same cycle as that elem_valid.
REQ-027 In DRAIN, bits SHALL be ignored with no error (covers trailing FCS); DRAIN→IDLE on the first cycle with axiiv=0.
REQ-028 If axiiv falls in HEADER, LOAD_A or LOAD_B, SHALL pulse pkt_err, discard any partial element and go to IDLE.
REQ-029 pkt_done and pkt_err SHALL never assert in the same cycle.
REQ-030 Dims of 1 (header fields 0) SHALL be legal; a 1×1×1 packet carries exactly 2 elements.
REQ-031 Gaps in axiiv are not supported: any deassertion terminates the packet.
REQ-032 dim_* SHALL hold the last accepted header until the next hdr_valid.

Reset
REQ-033 On rst=1 the FSM SHALL go to IDLE and the bit and index counters SHALL clear.
REQ-034 On rst=1 all pulse outputs SHALL go to 0, and elem_data, elem_row, elem_col, elem_mat and dim_* SHALL be 0.
REQ-035 rst mid-packet SHALL abort without pkt_err; bits seen while axiiv stays high after reset release SHALL be treated as a new packet start.

Structure
REQ-036 Package matrix_pkg SHALL hold the FSM state enum, HDR_W=16, the header field bit positions, ELEM_W and MAX_DIM defaults.
REQ-037 Sub-module bit_deserializer (shift register + bit counter, parameter WIDTH, outputs word and word_valid) SHALL be instantiated twice: 16-bit header and ELEM_W-bit element.
REQ-038 The block SHALL contain no memory; it feeds the matrix loader's write side directly.

Verification
REQ-039 Header 0x0000, A=0xA5, B=0x3C → hdr_valid with dims 1/1/1; elem (A,0,0,0xA5); elem (B,0,0,0x3C) with pkt_done.
REQ-040 m=2,k=3,n=2, elements 1..12 → A indices (0,0),(0,1),(0,2),(1,0)…(1,2); B indices (0,0),(1,0),(2,0),(0,1)…(2,1); values in order; 12 elem_valid pulses.
REQ-041 Header with bit0=1 → pkt_err, no hdr_valid, no elem_valid until axiiv low then high again.
REQ-042 axiiv drops after 4 bits of element 3 → pkt_err, exactly 2 elem_valid, FSM in IDLE; a following good packet parses correctly.
REQ-043 32 trailing bits after the last B element → no extra elem_valid, no pkt_err, return to IDLE when axiiv=0.
REQ-044 rst asserted mid-LOAD_A → all outputs 0 next cycle, no pkt_err; the next full packet parses correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the serial matrix packet parser: FSM states, header layout
// and default sizing.
package matrix_pkg;

  localparam int HDR_W       = 16;
  localparam int DEF_ELEM_W  = 8;
  localparam int DEF_MAX_DIM = 32;

  localparam int HDR_FIELD_W = 5;
  localparam int HDR_M_LSB   = 11;
  localparam int HDR_K_LSB   = 6;
  localparam int HDR_N_LSB   = 1;
  localparam int HDR_RSV_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_DRAIN
  } state_e;

  function automatic logic [HDR_FIELD_W-1:0] hdr_field(input logic [HDR_W-1:0] hdr,
                                                       input int lsb);
    return hdr[lsb +: HDR_FIELD_W];
  endfunction

endpackage

// File: rtl/bit_deserializer.sv
// MSB-first serial-to-parallel converter; word holds the last completed value and
// word_valid pulses the cycle after the WIDTH-th bit is sampled.
module bit_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q;
  logic             last_bit;

  assign shift_d  = (shift_q << 1) | WIDTH'(bit_in);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (flush) begin
        // Drop any partial word; the last completed word stays visible.
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (bit_valid) begin
        shift_q <= shift_d;
        if (last_bit) begin
          cnt_q        <= '0;
          word_q       <= shift_d;
          word_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/matrix_packet_parser.sv
// Parses a serial packet (16-bit header, A row-major, B column-major) into
// indexed element writes for a downstream matrix loader.
module matrix_packet_parser
  import matrix_pkg::*;
#(
  parameter int  ELEM_W  = DEF_ELEM_W,
  parameter int  MAX_DIM = DEF_MAX_DIM,
  localparam int DIM_W   = $clog2(MAX_DIM)
) (
  input  logic              eth_refclk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic              axiid,
  output logic              hdr_valid,
  output logic [DIM_W:0]    dim_m,
  output logic [DIM_W:0]    dim_k,
  output logic [DIM_W:0]    dim_n,
  output logic              elem_valid,
  output logic [ELEM_W-1:0] elem_data,
  output logic              elem_mat,
  output logic [DIM_W-1:0]  elem_row,
  output logic [DIM_W-1:0]  elem_col,
  output logic              pkt_done,
  output logic              pkt_err
);

  localparam logic [DIM_W:0]   ONE  = (DIM_W+1)'(1);
  localparam logic [DIM_W-1:0] IONE = DIM_W'(1);

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0]    hold_row_q, hold_col_q;
  logic                hold_mat_q;
  logic [DIM_W:0]      dm_q, dk_q, dn_q;
  logic [DIM_W:0]      hm, hk, hn;

  logic [HDR_W-1:0]    hdr_word;
  logic                hdr_wv;
  logic [ELEM_W-1:0]   elem_word;
  logic                elem_wv;

  logic hdr_bit_en, elem_bit_en, hdr_ok, abort;
  logic last_a, last_b, b_final;
  logic pkt_done_d, pkt_err_d;

  assign hm = (DIM_W+1)'(hdr_field(hdr_word, HDR_M_LSB)) + ONE;
  assign hk = (DIM_W+1)'(hdr_field(hdr_word, HDR_K_LSB)) + ONE;
  assign hn = (DIM_W+1)'(hdr_field(hdr_word, HDR_N_LSB)) + ONE;

  assign hdr_ok  = (state_q == ST_HEADER) && hdr_wv && axiiv && !hdr_word[HDR_RSV_BIT];
  assign last_a  = ({1'b0, row_q} == dm_q - ONE) && ({1'b0, col_q} == dk_q - ONE);
  assign last_b  = ({1'b0, row_q} == dk_q - ONE) && ({1'b0, col_q} == dn_q - ONE);
  assign b_final = (state_q == ST_LOAD_B) && elem_wv && last_b;

  // The first element bit shares its cycle with the header completion pulse.
  assign hdr_bit_en  = axiiv && ((state_q == ST_IDLE) || ((state_q == ST_HEADER) && !hdr_wv));
  assign elem_bit_en = axiiv && !b_final &&
                       ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B) || hdr_ok);

  bit_deserializer #(.WIDTH(HDR_W)) u_hdr_deser (
    .clk        (eth_refclk),
    .rst        (rst),
    .flush      (abort),
    .bit_valid  (hdr_bit_en),
    .bit_in     (axiid),
    .word       (hdr_word),
    .word_valid (hdr_wv)
  );

  bit_deserializer #(.WIDTH(ELEM_W)) u_elem_deser (
    .clk        (eth_refclk),
    .rst        (rst),
    .flush      (abort),
    .bit_valid  (elem_bit_en),
    .bit_in     (axiid),
    .word       (elem_word),
    .word_valid (elem_wv)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axiiv) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (hdr_ok) begin
          state_d = ST_LOAD_A;
          row_d   = '0;
          col_d   = '0;
        end else if (hdr_wv || !axiiv) begin
          pkt_err_d = 1'b1;
          abort     = 1'b1;
          state_d   = axiiv ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        if (elem_wv) begin
          if (last_a) begin
            state_d = ST_LOAD_B;
            row_d   = '0;
            col_d   = '0;
          end else if ({1'b0, col_q} == dk_q - ONE) begin
            col_d = '0;
            row_d = row_q + IONE;
          end else begin
            col_d = col_q + IONE;
          end
        end
        if (!axiiv) begin
          pkt_err_d = 1'b1;
          abort     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_LOAD_B: begin
        if (b_final) begin
          // A complete packet wins over axiiv falling in the same cycle.
          pkt_done_d = 1'b1;
          state_d    = ST_DRAIN;
          row_d      = '0;
          col_d      = '0;
        end else begin
          if (elem_wv) begin
            if ({1'b0, row_q} == dk_q - ONE) begin
              row_d = '0;
              col_d = col_q + IONE;
            end else begin
              row_d = row_q + IONE;
            end
          end
          if (!axiiv) begin
            pkt_err_d = 1'b1;
            abort     = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (!axiiv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      hold_row_q <= '0;
      hold_col_q <= '0;
      hold_mat_q <= 1'b0;
      dm_q       <= '0;
      dk_q       <= '0;
      dn_q       <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (elem_wv) begin
        hold_row_q <= row_q;
        hold_col_q <= col_q;
        hold_mat_q <= (state_q == ST_LOAD_B);
      end
      if (hdr_ok) begin
        dm_q <= hm;
        dk_q <= hk;
        dn_q <= hn;
      end
    end
  end

  // Outputs show the live value in the pulse cycle and the captured copy afterwards.
  assign hdr_valid  = hdr_ok && !rst;
  assign dim_m      = hdr_valid ? hm : dm_q;
  assign dim_k      = hdr_valid ? hk : dk_q;
  assign dim_n      = hdr_valid ? hn : dn_q;
  assign elem_valid = elem_wv && !rst;
  assign elem_data  = elem_word;
  assign elem_mat   = elem_wv ? (state_q == ST_LOAD_B) : hold_mat_q;
  assign elem_row   = elem_wv ? row_q : hold_row_q;
  assign elem_col   = elem_wv ? col_q : hold_col_q;
  assign pkt_done   = pkt_done_d && !rst;
  assign pkt_err    = pkt_err_d && !rst;

endmodule

// File: tb/tb_matrix_packet_parser.sv
// Directed bench for matrix_packet_parser: hand-built packets, element scoreboard
// fed by a negedge monitor.
module tb_matrix_packet_parser;

  logic        eth_refclk = 1'b0;
  logic        rst = 1'b1;
  logic        axiiv = 1'b0;
  logic        axiid = 1'b0;
  logic        hdr_valid, elem_valid, elem_mat, pkt_done, pkt_err;
  logic [5:0]  dim_m, dim_k, dim_n;
  logic [7:0]  elem_data;
  logic [4:0]  elem_row, elem_col;

  int n_checks = 0;
  int n_errs   = 0;
  int n_elem = 0, n_hdr = 0, n_done = 0, n_err = 0;
  logic [31:0] elem_q[$];
  logic [31:0] last_dims = '0;
  logic [31:0] exp_2x3x2[12];
  int base_elem, base_hdr, base_done, base_err, qi;

  always #5 eth_refclk = ~eth_refclk;

  matrix_packet_parser #(.ELEM_W(8), .MAX_DIM(32)) dut (
    .eth_refclk (eth_refclk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .hdr_valid  (hdr_valid),
    .dim_m      (dim_m),
    .dim_k      (dim_k),
    .dim_n      (dim_n),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_mat   (elem_mat),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int mat, input int row, input int col, input int data);
    return 32'((mat << 18) | (row << 13) | (col << 8) | data);
  endfunction

  function automatic logic [31:0] hdr(input int m, input int k, input int n, input int rsv);
    return 32'(((m - 1) << 11) | ((k - 1) << 6) | ((n - 1) << 1) | rsv);
  endfunction

  always @(negedge eth_refclk) begin
    if (elem_valid) begin
      elem_q.push_back({13'd0, elem_mat, elem_row, elem_col, elem_data});
      n_elem++;
      $display("elem mat=%0d row=%0d col=%0d data=%0h", elem_mat, elem_row, elem_col, elem_data);
    end
    if (hdr_valid) begin
      n_hdr++;
      last_dims = {14'd0, dim_m, dim_k, dim_n};
      $display("hdr m=%0d k=%0d n=%0d", dim_m, dim_k, dim_n);
    end
    if (pkt_done) begin
      n_done++;
      chk("done_with_elem", {31'd0, elem_valid}, 32'd1);
      chk("done_err_excl", {31'd0, pkt_err}, 32'd0);
      $display("pkt_done");
    end
    if (pkt_err) begin
      n_err++;
      $display("pkt_err");
    end
  end

  task automatic send_word(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      axiiv = 1'b1;
      axiid = v[i];
      @(posedge eth_refclk); #1;
    end
  endtask

  task automatic go_idle(input int n);
    axiiv = 1'b0;
    axiid = 1'b0;
    repeat (n) begin
      @(posedge eth_refclk); #1;
    end
  endtask

  task automatic snap();
    base_elem = n_elem;
    base_hdr  = n_hdr;
    base_done = n_done;
    base_err  = n_err;
    qi        = elem_q.size();
  endtask

  task automatic chk_next_elem(input string tag, input logic [31:0] exp);
    if (qi < elem_q.size()) begin
      chk(tag, elem_q[qi], exp);
    end else begin
      chk(tag, 32'hFFFF_FFFF, exp);
    end
    qi++;
  endtask

  initial begin
    exp_2x3x2[0]  = mk(0, 0, 0, 1);
    exp_2x3x2[1]  = mk(0, 0, 1, 2);
    exp_2x3x2[2]  = mk(0, 0, 2, 3);
    exp_2x3x2[3]  = mk(0, 1, 0, 4);
    exp_2x3x2[4]  = mk(0, 1, 1, 5);
    exp_2x3x2[5]  = mk(0, 1, 2, 6);
    exp_2x3x2[6]  = mk(1, 0, 0, 7);
    exp_2x3x2[7]  = mk(1, 1, 0, 8);
    exp_2x3x2[8]  = mk(1, 2, 0, 9);
    exp_2x3x2[9]  = mk(1, 0, 1, 10);
    exp_2x3x2[10] = mk(1, 1, 1, 11);
    exp_2x3x2[11] = mk(1, 2, 1, 12);

    // Reset state
    repeat (3) @(posedge eth_refclk);
    #1 rst = 1'b0;
    @(negedge eth_refclk);
    chk("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("rst_elem_valid", {31'd0, elem_valid}, 32'd0);
    chk("rst_pulses", {30'd0, pkt_done, pkt_err}, 32'd0);
    chk("rst_elem_data", {24'd0, elem_data}, 32'd0);
    chk("rst_dims", {14'd0, dim_m, dim_k, dim_n}, 32'd0);
    chk("rst_pos", {21'd0, elem_mat, elem_row, elem_col}, 32'd0);
    @(posedge eth_refclk); #1;

    // 1x1x1 packet
    snap();
    send_word(32'h0000, 16);
    send_word(32'hA5, 8);
    send_word(32'h3C, 8);
    go_idle(3);
    chk("t1_hdr_cnt", 32'(n_hdr - base_hdr), 32'd1);
    chk("t1_dims", last_dims, {14'd0, 6'd1, 6'd1, 6'd1});
    chk("t1_elem_cnt", 32'(n_elem - base_elem), 32'd2);
    chk_next_elem("t1_elemA", mk(0, 0, 0, 8'hA5));
    chk_next_elem("t1_elemB", mk(1, 0, 0, 8'h3C));
    chk("t1_done", 32'(n_done - base_done), 32'd1);
    chk("t1_err", 32'(n_err - base_err), 32'd0);

    // 2x3x2 packet, elements 1..12
    snap();
    send_word(hdr(2, 3, 2, 0), 16);
    for (int i = 1; i <= 12; i++) send_word(32'(i), 8);
    go_idle(3);
    chk("t2_dims", last_dims, {14'd0, 6'd2, 6'd3, 6'd2});
    chk("t2_elem_cnt", 32'(n_elem - base_elem), 32'd12);
    for (int i = 0; i < 12; i++) chk_next_elem($sformatf("t2_elem%0d", i), exp_2x3x2[i]);
    chk("t2_done", 32'(n_done - base_done), 32'd1);
    chk("t2_err", 32'(n_err - base_err), 32'd0);
    chk("t2_hold_data", {24'd0, elem_data}, 32'd12);
    chk("t2_hold_pos", {21'd0, elem_mat, elem_row, elem_col}, {21'd0, 1'b1, 5'd2, 5'd1});

    // Reserved header bit set, stream continues then drops
    snap();
    send_word(hdr(1, 1, 1, 1), 16);
    send_word(32'hFFFF_FF, 24);
    go_idle(3);
    chk("t3_err", 32'(n_err - base_err), 32'd1);
    chk("t3_hdr_cnt", 32'(n_hdr - base_hdr), 32'd0);
    chk("t3_elem_cnt", 32'(n_elem - base_elem), 32'd0);
    chk("t3_dims_held", {14'd0, dim_m, dim_k, dim_n}, {14'd0, 6'd2, 6'd3, 6'd2});

    // Truncation after 4 bits of element 3, then a good packet
    snap();
    send_word(hdr(2, 3, 2, 0), 16);
    send_word(32'h01, 8);
    send_word(32'h02, 8);
    send_word(32'hA, 4);
    go_idle(3);
    chk("t4_err", 32'(n_err - base_err), 32'd1);
    chk("t4_elem_cnt", 32'(n_elem - base_elem), 32'd2);
    chk("t4_done", 32'(n_done - base_done), 32'd0);
    snap();
    send_word(hdr(1, 1, 1, 0), 16);
    send_word(32'h11, 8);
    send_word(32'h22, 8);
    go_idle(3);
    chk("t4_good_cnt", 32'(n_elem - base_elem), 32'd2);
    chk_next_elem("t4_goodA", mk(0, 0, 0, 8'h11));
    chk_next_elem("t4_goodB", mk(1, 0, 0, 8'h22));
    chk("t4_good_done", 32'(n_done - base_done), 32'd1);
    chk("t4_good_err", 32'(n_err - base_err), 32'd0);

    // 32 trailing bits after the last B element
    snap();
    send_word(hdr(1, 1, 1, 0), 16);
    send_word(32'h5A, 8);
    send_word(32'hC3, 8);
    send_word(32'hDEAD_BEEF, 32);
    go_idle(3);
    chk("t5_elem_cnt", 32'(n_elem - base_elem), 32'd2);
    chk_next_elem("t5_elemA", mk(0, 0, 0, 8'h5A));
    chk_next_elem("t5_elemB", mk(1, 0, 0, 8'hC3));
    chk("t5_done", 32'(n_done - base_done), 32'd1);
    chk("t5_err", 32'(n_err - base_err), 32'd0);

    // Reset in the middle of LOAD_A
    snap();
    send_word(hdr(2, 3, 2, 0), 16);
    send_word(32'h01, 8);
    send_word(32'h5, 3);
    rst = 1'b1;
    axiiv = 1'b1;
    @(posedge eth_refclk); #1;
    rst = 1'b0;
    axiiv = 1'b0;
    @(negedge eth_refclk);
    chk("t6_rst_data", {24'd0, elem_data}, 32'd0);
    chk("t6_rst_dims", {14'd0, dim_m, dim_k, dim_n}, 32'd0);
    chk("t6_rst_pos", {21'd0, elem_mat, elem_row, elem_col}, 32'd0);
    chk("t6_rst_pulses", {28'd0, hdr_valid, elem_valid, pkt_done, pkt_err}, 32'd0);
    go_idle(2);
    chk("t6_no_err", 32'(n_err - base_err), 32'd0);
    snap();
    send_word(hdr(1, 1, 1, 0), 16);
    send_word(32'h77, 8);
    send_word(32'h88, 8);
    go_idle(3);
    chk("t6_elem_cnt", 32'(n_elem - base_elem), 32'd2);
    chk_next_elem("t6_elemA", mk(0, 0, 0, 8'h77));
    chk_next_elem("t6_elemB", mk(1, 0, 0, 8'h88));
    chk("t6_done", 32'(n_done - base_done), 32'd1);
    chk("t6_err", 32'(n_err - base_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
